// File: rtl/ex_mem_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_reg
//   Pipeline register between the execute stage and the memory-access stage.
//   Captures the EX results each cycle and presents them to MEM:
//     - GPR write-back information (destination, enable, data).
//     - HI/LO write information (values, enable).
//   Stalls, bubble insertion and flush are handled here.
//   The 64-bit partial product and the accumulate cycle count are held and
//   looped back to EX.  This lets two-cycle madd/msub operations survive
//   while EX is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears every output)
//   stall      stall request vector from the pipeline controller
//   flush      squash the EX->MEM transfer (exception/flush)
//   ex_wd      EX destination register address
//   ex_wreg    EX GPR write enable
//   ex_wdata   EX GPR write data
//   ex_hi      EX HI write value
//   ex_lo      EX LO write value
//   ex_whilo   EX HI/LO write enable
//   hilo_i     partial accumulate result from EX
//   cnt_i      accumulate cycle count from EX
//   mem_wd     registered destination address to MEM
//   mem_wreg   registered GPR write enable to MEM
//   mem_wdata  registered GPR write data to MEM
//   mem_hi     registered HI value to MEM
//   mem_lo     registered LO value to MEM
//   mem_whilo  registered HI/LO write enable to MEM
//   hilo_o     held partial accumulate result back to EX
//   cnt_o      held accumulate cycle count back to EX
// ----------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int STALL_W       = 6,
    parameter int EX_STALL_BIT  = 3,
    parameter int MEM_STALL_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic [ADDR_W-1:0]   mem_wd_q,    mem_wd_d;
    logic                mem_wreg_q,  mem_wreg_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   mem_hi_q,    mem_hi_d;
    logic [DATA_W-1:0]   mem_lo_q,    mem_lo_d;
    logic                mem_whilo_q, mem_whilo_d;
    logic [2*DATA_W-1:0] hilo_q,      hilo_d;
    logic [1:0]          cnt_q,       cnt_d;

    logic mem_stall;
    logic ex_stall;

    assign mem_stall = stall[MEM_STALL_BIT];
    assign ex_stall  = stall[EX_STALL_BIT];

    // Priority: flush > MEM stall (hold) > EX stall (bubble) > advance.
    // A MEM stall without an EX stall should never come from the controller.
    // If it does, the hold branch still wins, so the state is never corrupted.
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;

        if (flush) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
            hilo_d      = '0;
            cnt_d       = '0;
        end else if (mem_stall) begin
            // hold everything
        end else if (ex_stall) begin
            // Bubble into MEM.  The multiply-accumulate state is kept
            // so EX can resume the second madd/msub cycle after the stall.
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
        end else begin
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            mem_whilo_d = ex_whilo;
            hilo_d      = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_whilo_q <= 1'b0;
            hilo_q      <= '0;
            cnt_q       <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_whilo_q <= mem_whilo_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign mem_whilo = mem_whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int STALL_W = 6;
    localparam int VW = ADDR_W + 1 + DATA_W * 3 + 1 + 2 * DATA_W + 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] act;
    assign act = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};

    // Reference model: the observable register contents, updated per edge
    // from the rule list (flush, MEM hold, EX bubble, advance).
    logic [ADDR_W-1:0]   e_wd;
    logic                e_wreg;
    logic [DATA_W-1:0]   e_wdata, e_hi, e_lo;
    logic                e_whilo;
    logic [2*DATA_W-1:0] e_hilo;
    logic [1:0]          e_cnt;

    function automatic logic [VW-1:0] exp_vec();
        return {e_wd, e_wreg, e_wdata, e_hi, e_lo, e_whilo, e_hilo, e_cnt};
    endfunction

    task automatic model_clear();
        e_wd = '0; e_wreg = 0; e_wdata = '0; e_hi = '0; e_lo = '0;
        e_whilo = 0; e_hilo = '0; e_cnt = '0;
    endtask

    task automatic model_step();
        if (flush) begin
            model_clear();
        end else if (stall[4]) begin
            // registers unchanged
        end else if (stall[3]) begin
            e_wd = '0; e_wreg = 0; e_wdata = '0; e_hi = '0; e_lo = '0; e_whilo = 0;
            e_hilo = hilo_i;
            e_cnt = cnt_i;
        end else begin
            e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
            e_hi = ex_hi; e_lo = ex_lo; e_whilo = ex_whilo;
            e_hilo = '0;
            e_cnt = '0;
        end
    endtask

    // Advance one edge; inputs are stable around the edge, outputs read 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_ex();
        ex_wd = ADDR_W'($urandom);
        ex_wreg = 1'($urandom);
        ex_wdata = $urandom;
        ex_hi = $urandom;
        ex_lo = $urandom;
        ex_whilo = 1'($urandom);
        hilo_i = {$urandom, $urandom};
        cnt_i = 2'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; stall = '0; flush = 0; rand_ex();
        model_clear();
        tick();
        n_cmp++;
        if (act !== '0) begin n_err++; $display("FAIL reset_init: got %h want 0", act); end
        rst = 0;
        ex_wreg = 1; ex_wdata = 32'h1234_5678;
        tick();
        n_cmp++;
        if (mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL reset_preload: wreg=%b wdata=%h want 1/12345678", mem_wreg, mem_wdata);
        end
        // Assert reset between edges: outputs must clear with no clock edge.
        #1 rst = 1;
        #1;
        model_clear();
        n_cmp++;
        if (act !== '0) begin n_err++; $display("FAIL reset_async: got %h want 0", act); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (act !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", act); end
        end
        rst = 0;
    endtask

    task automatic test_advance();
        rand_ex();
        ex_wd = 5'd7; ex_wdata = 32'hDEADBEEF; ex_wreg = 1; stall = '0; flush = 0;
        tick();
        n_cmp++;
        if (mem_wd !== 5'd7 || mem_wdata !== 32'hDEADBEEF || mem_wreg !== 1'b1 ||
            hilo_o !== '0 || cnt_o !== 2'd0) begin
            n_err++; $display("FAIL advance: wd=%0d wdata=%h wreg=%b hilo=%h cnt=%0d want 7/DEADBEEF/1/0/0",
                              mem_wd, mem_wdata, mem_wreg, hilo_o, cnt_o);
        end
        n_cmp++;
        if (act !== exp_vec()) begin n_err++; $display("FAIL advance_full: got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_ex_stall();
        ex_wreg = 1; ex_whilo = 1;
        stall = 6'b001111; hilo_i = 64'h1_00000002; cnt_i = 2'd1;
        tick();
        n_cmp++;
        if (mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || hilo_o !== 64'h1_00000002 || cnt_o !== 2'd1) begin
            n_err++; $display("FAIL ex_stall: wreg=%b whilo=%b hilo=%h cnt=%0d want 0/0/100000002/1",
                              mem_wreg, mem_whilo, hilo_o, cnt_o);
        end
        n_cmp++;
        if (act !== exp_vec()) begin n_err++; $display("FAIL ex_stall_full: got %h want %h", act, exp_vec()); end
        stall = '0;
        tick();
        n_cmp++;
        if (hilo_o !== '0 || cnt_o !== 2'd0) begin
            n_err++; $display("FAIL ex_stall_release: hilo=%h cnt=%0d want 0/0", hilo_o, cnt_o);
        end
    endtask

    task automatic test_mem_stall();
        rand_ex();
        ex_hi = 32'h5; ex_whilo = 1; stall = '0;
        tick();
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            ex_whilo = 0;
            tick();
            n_cmp++;
            if (mem_hi !== 32'h5 || mem_whilo !== 1'b1 || act !== exp_vec()) begin
                n_err++; $display("FAIL mem_stall_%0d: hi=%h whilo=%b got %h want %h", i, mem_hi, mem_whilo, act, exp_vec());
            end
        end
        // MEM stalled without EX stalled still holds.
        stall = 6'b010000;
        rand_ex();
        tick();
        n_cmp++;
        if (mem_hi !== 32'h5 || act !== exp_vec()) begin
            n_err++; $display("FAIL mem_only_stall: got %h want %h", act, exp_vec());
        end
        stall = '0;
    endtask

    task automatic test_flush();
        rand_ex();
        ex_wreg = 1; ex_whilo = 1; cnt_i = 2'd2;
        stall = '0;
        tick();
        flush = 1; stall = 6'b011111;
        rand_ex();
        ex_wreg = 1; ex_whilo = 1;
        tick();
        n_cmp++;
        if (act !== '0) begin n_err++; $display("FAIL flush_priority: got %h want 0", act); end
        flush = 0; stall = '0;
    endtask

    task automatic test_back_to_back();
        stall = '0; flush = 0;
        for (int i = 1; i <= 4; i++) begin
            rand_ex();
            ex_wd = ADDR_W'(i);
            tick();
            n_cmp++;
            if (mem_wd !== ADDR_W'(i) || act !== exp_vec()) begin
                n_err++; $display("FAIL back_to_back_%0d: mem_wd=%0d got %h want %h", i, mem_wd, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            case ($urandom_range(0, 4))
                0: stall = 6'b001111;
                1: stall = 6'b011111;
                2: stall = STALL_W'($urandom);
                default: stall = '0;
            endcase
            flush = ($urandom_range(0, 9) == 0);
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, act, exp_vec());
            end
            n_cmp++;
            if ((stall[3] && !stall[4] || flush) && (mem_wreg !== 1'b0 || mem_whilo !== 1'b0)) begin
                n_err++; $display("FAIL bubble_we_%0d: wreg=%b whilo=%b want 0/0", i, mem_wreg, mem_whilo);
            end
        end
        stall = '0; flush = 0;
    endtask

    initial begin
        rst = 1; stall = '0; flush = 0;
        ex_wd = '0; ex_wreg = 0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
        ex_whilo = 0; hilo_i = '0; cnt_i = '0;
        model_clear();
        test_reset();
        test_advance();
        test_ex_stall();
        test_mem_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
